// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared types and default widths for the decode stage.
//               br_mode_e   - branch compare mode encoding
//               dec_out_t   - output slot layout at the default widths
//               DEF_*       - default parameter values for decode_stage_p
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_IMM_W    = 19;
  localparam int DEF_BR_SHIFT = 2;
  localparam int DEF_AW       = $clog2(DEF_NUM_REGS);

  typedef enum logic [1:0] {
    BR_EQZ = 2'b00,
    BR_NEZ = 2'b01,
    BR_LTZ = 2'b10,
    BR_EQ  = 2'b11
  } br_mode_e;

  // Slot contents as seen by execute in the default configuration.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data1;
    logic [DEF_DATA_W-1:0] data2;
    logic [DEF_DATA_W-1:0] imm_ext;
    logic [DEF_DATA_W-1:0] branch_dir;
    logic [DEF_AW-1:0]     dst;
    logic                  is_load;
    logic                  pc_select;
  } dec_out_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_p.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_p
// Description : Parametrised 2-read / 1-write register file, synchronous
//               reset to zero, combinational reads.
//               Macro DECO_WB_BYPASS_EN: when defined, a read of the address
//               being written this cycle returns the write data.
// Ports       : clk, rst            - clock, sync active-high reset
//               we_i/waddr_i/wdata_i - write port
//               raddr_a_i/rdata_a_o  - read port A
//               raddr_b_i/rdata_b_o  - read port B
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_p #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

`ifdef DECO_WB_BYPASS_EN
  assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
  assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];
`else
  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];
`endif

endmodule
`default_nettype wire

// File: rtl/decode_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_p
// Description : Decode stage: register file read, immediate sign-extension,
//               branch offset shift, destination select, branch compare and
//               a load scoreboard that stalls on load-use hazards. Results
//               land in a valid/ready output slot one cycle after accept.
//               Macro DECO_WB_BYPASS_EN: when defined, writeback data is
//               forwarded to same-cycle reads and a pending bit being cleared
//               this cycle no longer stalls (load-use penalty one cycle less).
// Ports       : clk, rst                      - clock, sync active-high reset
//               in_valid/in_ready             - fetch handshake
//               ra, rb, rd, dst_sel, imm,
//               branch, br_mode, is_load      - instruction fields
//               flush                         - kill slot, block capture
//               wb_en/wb_addr/wb_data         - writeback port
//               out_valid/out_ready           - execute handshake
//               out_data1/2, out_imm_ext,
//               out_branch_dir, out_pc_select,
//               out_dst, out_is_load          - slot contents
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int IMM_W    = DEF_IMM_W,
  parameter int BR_SHIFT = DEF_BR_SHIFT,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  input  logic [AW-1:0]     rd,
  input  logic              dst_sel,
  input  logic [IMM_W-1:0]  imm,
  input  logic              branch,
  input  logic [1:0]        br_mode,
  input  logic              is_load,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_imm_ext,
  output logic [DATA_W-1:0] out_branch_dir,
  output logic              out_pc_select,
  output logic [AW-1:0]     out_dst,
  output logic              out_is_load
);

  // Same field order as dec_out_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] branch_dir;
    logic [AW-1:0]     dst;
    logic              is_load;
    logic              pc_select;
  } slot_t;

  slot_t                slot_q, slot_d;
  logic                 valid_q, valid_d;
  logic [NUM_REGS-1:0]  pending_q, pending_d;

  logic [DATA_W-1:0]    rdata_a, rdata_b;
  logic [DATA_W-1:0]    imm_ext;
  logic [AW-1:0]        dst;
  logic                 cmp;
  logic                 hazard;
  logic                 accept;
  logic [NUM_REGS-1:0]  wb_clr, flush_clr, set_mask, pend_eff;

  reg_file_p #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (ra),
    .raddr_b_i (rb),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
  );

  assign dst     = dst_sel ? rb : rd;
  assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    cmp = 1'b0;
    case (br_mode_e'(br_mode))
      BR_EQZ:  cmp = (rdata_a == '0);
      BR_NEZ:  cmp = (rdata_a != '0);
      BR_LTZ:  cmp = rdata_a[DATA_W-1];
      BR_EQ:   cmp = (rdata_a == rdata_b);
      default: cmp = 1'b0;
    endcase
  end

  // One-hot masks for the scoreboard. A flushed load never wrote back, so
  // its destination must be released here or readers would stall forever.
  always_comb begin
    wb_clr    = '0;
    flush_clr = '0;
    set_mask  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wb_clr[i]    = wb_en && (wb_addr == AW'(i));
      flush_clr[i] = flush && valid_q && slot_q.is_load && (slot_q.dst == AW'(i));
      set_mask[i]  = accept && is_load && (dst == AW'(i));
    end
  end

`ifdef DECO_WB_BYPASS_EN
  assign pend_eff = pending_q & ~wb_clr;
`else
  assign pend_eff = pending_q;
`endif

  assign hazard   = in_valid && (pend_eff[ra] || pend_eff[rb] || pend_eff[dst]);
  assign in_ready = !hazard && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Set is applied after the clears so a same-cycle set wins.
  assign pending_d = (pending_q & ~wb_clr & ~flush_clr) | set_mask;

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d            = 1'b1;
      slot_d.data1       = rdata_a;
      slot_d.data2       = rdata_b;
      slot_d.imm_ext     = imm_ext;
      slot_d.branch_dir  = imm_ext << BR_SHIFT;
      slot_d.dst         = dst;
      slot_d.is_load     = is_load;
      slot_d.pc_select   = branch && cmp;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      slot_q    <= '0;
      pending_q <= '0;
    end else begin
      valid_q   <= valid_d;
      slot_q    <= slot_d;
      pending_q <= pending_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_data1      = slot_q.data1;
  assign out_data2      = slot_q.data2;
  assign out_imm_ext    = slot_q.imm_ext;
  assign out_branch_dir = slot_q.branch_dir;
  assign out_pc_select  = slot_q.pc_select;
  assign out_dst        = slot_q.dst;
  assign out_is_load    = slot_q.is_load;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage_p
// Description : Directed self-checking bench for decode_stage_p (default
//               parameters). Expected stall timing follows DECO_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  ra, rb, rd;
  logic        dst_sel;
  logic [18:0] imm;
  logic        branch;
  logic [1:0]  br_mode;
  logic        is_load, flush;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data1, out_data2, out_imm_ext, out_branch_dir;
  logic        out_pc_select;
  logic [3:0]  out_dst;
  logic        out_is_load;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage_p dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .ra(ra), .rb(rb), .rd(rd), .dst_sel(dst_sel), .imm(imm),
    .branch(branch), .br_mode(br_mode), .is_load(is_load), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data1(out_data1), .out_data2(out_data2),
    .out_imm_ext(out_imm_ext), .out_branch_dir(out_branch_dir),
    .out_pc_select(out_pc_select), .out_dst(out_dst), .out_is_load(out_is_load)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                       input logic ds, input logic [18:0] im, input logic br,
                       input logic [1:0] md, input logic ld);
    ra = a; rb = b; rd = d; dst_sel = ds; imm = im;
    branch = br; br_mode = md; is_load = ld; in_valid = 1'b1;
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; ra = '0; rb = '0; rd = '0; dst_sel = 1'b0; imm = '0;
    branch = 1'b0; br_mode = 2'b00; is_load = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    out_ready = 1'b1;
    idle();
    step(); step();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data1 !== 32'h0) begin bad++; $display("FAIL reset_data1 got=%h exp=0", out_data1); end
    total++; if (out_imm_ext !== 32'h0) begin bad++; $display("FAIL reset_imm got=%h exp=0", out_imm_ext); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_regfile_read();
    wb_write(4'd3, 32'h0000_0005);
    wb_write(4'd1, 32'h8000_0000);
    wb_write(4'd2, 32'h8000_0000);
    drive(4'd3, 4'd0, 4'd5, 1'b0, 19'h0, 1'b0, 2'b00, 1'b0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rd_in_ready got=%b exp=1", in_ready); end
    step();
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rd_valid got=%b exp=1", out_valid); end
    total++; if (out_data1 !== 32'h5) begin bad++; $display("FAIL rd_data1 got=%h exp=00000005", out_data1); end
    total++; if (out_data2 !== 32'h0) begin bad++; $display("FAIL rd_data2 got=%h exp=0", out_data2); end
    total++; if (out_dst !== 4'd5) begin bad++; $display("FAIL rd_dst got=%0d exp=5", out_dst); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rd_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_imm();
    drive(4'd0, 4'd9, 4'd5, 1'b1, 19'h7FFFF, 1'b0, 2'b00, 1'b0);
    step();
    total++; if (out_imm_ext !== 32'hFFFF_FFFF) begin bad++; $display("FAIL imm_neg_ext got=%h exp=ffffffff", out_imm_ext); end
    total++; if (out_branch_dir !== 32'hFFFF_FFFC) begin bad++; $display("FAIL imm_neg_dir got=%h exp=fffffffc", out_branch_dir); end
    total++; if (out_dst !== 4'd9) begin bad++; $display("FAIL dst_sel_rb got=%0d exp=9", out_dst); end
    drive(4'd0, 4'd9, 4'd5, 1'b0, 19'h00010, 1'b0, 2'b00, 1'b0);
    step();
    idle();
    total++; if (out_imm_ext !== 32'h10) begin bad++; $display("FAIL imm_pos_ext got=%h exp=00000010", out_imm_ext); end
    total++; if (out_branch_dir !== 32'h40) begin bad++; $display("FAIL imm_pos_dir got=%h exp=00000040", out_branch_dir); end
    total++; if (out_dst !== 4'd5) begin bad++; $display("FAIL dst_sel_rd got=%0d exp=5", out_dst); end
    step();
  endtask

  task automatic test_branch();
    // R1 = R2 = 0x8000_0000, R3 = 5
    drive(4'd1, 4'd0, 4'd0, 1'b0, 19'h0, 1'b1, 2'b10, 1'b0); step();
    total++; if (out_pc_select !== 1'b1) begin bad++; $display("FAIL br_ltz got=%b exp=1", out_pc_select); end
    drive(4'd1, 4'd0, 4'd0, 1'b0, 19'h0, 1'b1, 2'b00, 1'b0); step();
    total++; if (out_pc_select !== 1'b0) begin bad++; $display("FAIL br_eqz got=%b exp=0", out_pc_select); end
    drive(4'd1, 4'd0, 4'd0, 1'b0, 19'h0, 1'b1, 2'b01, 1'b0); step();
    total++; if (out_pc_select !== 1'b1) begin bad++; $display("FAIL br_nez got=%b exp=1", out_pc_select); end
    drive(4'd1, 4'd2, 4'd0, 1'b0, 19'h0, 1'b1, 2'b11, 1'b0); step();
    total++; if (out_pc_select !== 1'b1) begin bad++; $display("FAIL br_eq_same got=%b exp=1", out_pc_select); end
    drive(4'd1, 4'd3, 4'd0, 1'b0, 19'h0, 1'b1, 2'b11, 1'b0); step();
    total++; if (out_pc_select !== 1'b0) begin bad++; $display("FAIL br_eq_diff got=%b exp=0", out_pc_select); end
    drive(4'd1, 4'd0, 4'd0, 1'b0, 19'h0, 1'b0, 2'b10, 1'b0); step();
    total++; if (out_pc_select !== 1'b0) begin bad++; $display("FAIL br_not_branch got=%b exp=0", out_pc_select); end
    drive(4'd0, 4'd0, 4'd0, 1'b0, 19'h0, 1'b1, 2'b00, 1'b0); step();
    total++; if (out_pc_select !== 1'b1) begin bad++; $display("FAIL br_eqz_zero got=%b exp=1", out_pc_select); end
    idle();
    step();
  endtask

  task automatic test_load_use();
    logic exp_rdy;
`ifdef DECO_WB_BYPASS_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    drive(4'd0, 4'd0, 4'd4, 1'b0, 19'h0, 1'b0, 2'b00, 1'b1); step();
    total++; if (out_is_load !== 1'b1) begin bad++; $display("FAIL lu_is_load got=%b exp=1", out_is_load); end
    drive(4'd4, 4'd0, 4'd6, 1'b0, 19'h0, 1'b0, 2'b00, 1'b0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_stall0 got=%b exp=0", in_ready); end
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lu_stall1 got=%b exp=0", in_ready); end
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h0000_1234;
    #1;
    total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL lu_wb_cycle_ready got=%b exp=%b", in_ready, exp_rdy); end
    step();
    wb_en = 1'b0;
`ifndef DECO_WB_BYPASS_EN
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lu_after_wb_ready got=%b exp=1", in_ready); end
    step();
`endif
    idle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lu_valid got=%b exp=1", out_valid); end
    total++; if (out_data1 !== 32'h1234) begin bad++; $display("FAIL lu_operand got=%h exp=00001234", out_data1); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(4'd3, 4'd0, 4'd7, 1'b0, 19'h0, 1'b0, 2'b00, 1'b0); step();
    drive(4'd1, 4'd0, 4'd8, 1'b0, 19'h00010, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      total++; if (out_valid !== 1'b1 || out_data1 !== 32'h5 || out_dst !== 4'd7)
        begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d exp=1/00000005/7", i, out_valid, out_data1, out_dst); end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    step();
    idle();
    total++; if (out_valid !== 1'b1 || out_data1 !== 32'h8000_0000 || out_dst !== 4'd8)
      begin bad++; $display("FAIL bp_next got=%b/%h/%0d exp=1/80000000/8", out_valid, out_data1, out_dst); end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(4'd0, 4'd0, 4'd7, 1'b0, 19'h0, 1'b0, 2'b00, 1'b1); step();
    idle();
    flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_in_ready got=%b exp=0", in_ready); end
    step();
    flush = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b exp=0", out_valid); end
    out_ready = 1'b1;
    drive(4'd7, 4'd0, 4'd6, 1'b0, 19'h0, 1'b0, 2'b00, 1'b0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_reader_ready got=%b exp=1", in_ready); end
    step();
    idle();
    total++; if (out_valid !== 1'b1 || out_data1 !== 32'h0)
      begin bad++; $display("FAIL fl_reader got=%b/%h exp=1/00000000", out_valid, out_data1); end
    step();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b1;
    drive(4'd3, 4'd0, 4'd9, 1'b0, 19'h00010, 1'b0, 2'b00, 1'b1); step();
    drive(4'd9, 4'd0, 4'd1, 1'b0, 19'h0, 1'b0, 2'b00, 1'b0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rs_stall got=%b exp=0", in_ready); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data1 !== 32'h0 || out_imm_ext !== 32'h0 || out_dst !== 4'd0 || out_is_load !== 1'b0)
      begin bad++; $display("FAIL rs_outputs got=%b/%h/%h/%0d/%b exp=0/0/0/0/0", out_valid, out_data1, out_imm_ext, out_dst, out_is_load); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rs_scoreboard got=%b exp=1", in_ready); end
    drive(4'd3, 4'd9, 4'd1, 1'b0, 19'h0, 1'b0, 2'b00, 1'b0); step();
    idle();
    total++; if (out_valid !== 1'b1 || out_data1 !== 32'h0)
      begin bad++; $display("FAIL rs_regfile got=%b/%h exp=1/00000000", out_valid, out_data1); end
    step();
  endtask

  initial begin
    test_reset();
    test_regfile_read();
    test_imm();
    test_branch();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
Parametrised next-generation decode stage of the pipelined core. It holds the architectural register file (two read ports, one writeback port) and does immediate sign-extension, branch-target shift, destination select and multi-mode branch compare. A load scoreboard stalls on load-use hazards. Results are registered into a valid/ready output slot that feeds execute.

Parameters:
DATA_W, 32, register/data width
NUM_REGS, 16, register count; address width AW = $clog2(NUM_REGS)
IMM_W, 19, raw immediate width (IMM_W < DATA_W)
BR_SHIFT, 2, left shift applied to the extended immediate to form the branch offset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  decode accepts this cycle
ra, rb, rd  in  AW  source A, source B, destination field
dst_sel  in  1  0: destination=rd, 1: destination=rb
imm  in  IMM_W  raw immediate
branch  in  1  instruction is a conditional branch
br_mode  in  2  compare mode
is_load  in  1  instruction is a load (result arrives later via writeback)
flush  in  1  kill output slot and block capture this cycle
wb_en  in  1  writeback enable
wb_addr  in  AW  writeback register
wb_data  in  DATA_W  writeback value
out_valid  out  1  output slot valid
out_ready  in  1  execute accepts the slot
out_data1, out_data2  out  DATA_W  operands read from ra, rb
out_imm_ext  out  DATA_W  sign-extended immediate
out_branch_dir  out  DATA_W  out_imm_ext << BR_SHIFT
out_pc_select  out  1  branch taken
out_dst  out  AW  selected destination
out_is_load  out  1  load flag

Behaviour:
- Reset (synchronous): all registers = 0. Scoreboard is cleared. out_valid=0 and all out_* data = 0.
- Register file: written at the clk edge when wb_en=1. Reads are combinational.
- Scoreboard pending[NUM_REGS]: set bit dst on accept when is_load=1. Clear bit wb_addr when wb_en=1. If set and clear hit the same register in one cycle, set wins.
- hazard = in_valid && (pending[ra] || pending[rb] || pending[dst]), after bypass relief (see Optional Feature).
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Accept = in_valid && in_ready. The slot is loaded 1 cycle later (latency 1) with operands, extended immediate, branch offset, dst, is_load and pc_select.
- Slot update rules:
  - out_ready && !accept: out_valid -> 0.
  - No out_ready: slot holds all values stable.
- Branch compare, evaluated on the operands being captured:
  - 00 EQZ: data1 == 0
  - 01 NEZ: data1 != 0
  - 10 LTZ: data1 signed < 0
  - 11 EQ: data1 == data2
  - pc_select = branch && compare; forced 0 when branch=0.
- Immediate: sign-extend imm[IMM_W-1] to DATA_W. branch_dir is a logical left shift with upper bits dropped.
- flush: out_valid -> 0 next edge. If the killed slot held a load, its pending[out_dst] bit is cleared, unless the same-cycle set rule applies. Flush has priority over out_ready. Pending bits of older loads are untouched.
- Writeback to a register while a read targets it: see Optional Feature.
- Reset mid-stall: everything returns to reset values; a stalled instruction is dropped and fetch must re-present it.

Optional Feature:
Macro DECO_WB_BYPASS_EN.
- Defined:
  - A read whose address equals wb_addr while wb_en=1 returns wb_data in the same cycle.
  - A pending bit being cleared this cycle does not cause a hazard, so the load-use stall ends in the writeback cycle.
- Undefined:
  - Reads return the pre-write value.
  - The hazard persists until the cycle after writeback, giving a load-use penalty 1 cycle longer.

Decomposition:
- Package decode_pkg holds:
  - br_mode_e enum (BR_EQZ, BR_NEZ, BR_LTZ, BR_EQ)
  - packed struct dec_out_t for the slot contents
  - default-width localparams
- One natural sub-module, reg_file_p: a parametrised 2R1W register file with optional bypass. The scoreboard and compare logic stay in decode_stage_p.

Test Plan:
- Write R3=0x0000_0005 via wb, then decode ra=3, rb=0 with out_ready=1 -> out_data1=5, out_valid=1 one cycle after accept.
- imm=19'h7FFFF, BR_SHIFT=2 -> out_imm_ext=0xFFFF_FFFF, out_branch_dir=0xFFFF_FFFC. imm=19'h00010 -> 0x10 / 0x40.
- branch=1, R1=0x8000_0000: br_mode=10 -> pc_select=1, br_mode=00 -> 0. br_mode=11 with R1==R2 -> 1. branch=0 with any mode -> 0.
- Load to R4 accepted, next instruction ra=4 -> in_ready=0 until wb_en writes R4. Stall lasts until the wb cycle with DECO_WB_BYPASS_EN, or wb+1 without it. Operand equals wb_data.
- out_ready=0 for 3 cycles with a valid slot -> slot contents stable and in_ready=0. Release -> next instruction loads with no gap.
- Load in slot and flush=1 -> out_valid=0 next cycle, pending[dst] cleared, and a following reader of dst is not stalled. rst=1 mid-stall -> all outputs 0 and scoreboard empty.
